dz_scan: RTL and testbench
==========================

DZ_SCAN -- requirements
Module: dz_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clk cycles per displayed row (legal range 2..65535).
REQ-002 SHALL have parameter BLINK_FRAMES, default 32: frames per blink half-period (legal range 1..255).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port dst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port num, input, 4: image index. 0..13 are game artwork, 14 is the all-on test pattern, 15 is blank.
REQ-006 SHALL have port fail, input, 1: 1 draws the image in green, 0 draws it in red.
REQ-007 SHALL have port blink, input, 1: 1 enables blinking of the image.
REQ-008 SHALL have port row, output, 8: active-low one-hot row select.
REQ-009 SHALL have port colg, output, 8: active-high green column data.
REQ-010 SHALL have port colr, output, 8: active-high red column data.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse marking the start of each frame.

Function
REQ-012 SHALL hold a divider counter div, 0..SCAN_DIV-1, incrementing every clk and wrapping to 0 after its terminal count (TC).
REQ-013 SHALL advance row index ridx (0..7) by one at each TC; ridx 7 wraps to 0.
REQ-014 SHALL treat TC with ridx==7 as the frame boundary.
REQ-015 SHALL latch num, fail and blink into shadow registers only at the frame boundary; input changes at any other time have no visible effect until the next boundary.
REQ-016 SHALL register all outputs, so each output reflects the state of the previous cycle (1-cycle latency).
REQ-017 SHALL drive row = ~(8'b1 << ridx).
REQ-018 SHALL use pattern byte d = ROM[num_l][ridx], where bit 7 is the leftmost column.
REQ-019 SHALL hold ROM entries 0..13 per the game art table; every row of entry 14 SHALL be 8'hFF and every row of entry 15 SHALL be 8'h00.
REQ-020 SHALL drive colg = fail_l ? d : 8'h00 and colr = fail_l ? 8'h00 : d; both colours are never lit at once.
REQ-021 SHALL keep a frame counter, 0..BLINK_FRAMES-1, incrementing at each frame boundary; on wrap it SHALL toggle blink phase ph.
REQ-022 SHALL force colg = colr = 8'h00 while blink_l==1 and ph==0; row scanning SHALL continue unchanged.
REQ-023 SHALL run the frame counter and ph whether or not blink is enabled.
REQ-024 SHALL assert frame_done for exactly one cycle, on the same cycle the outputs first show ridx 0 of a new frame.
REQ-025 SHALL give a full frame a duration of exactly 8*SCAN_DIV cycles.

Reset
REQ-026 While dst==1, asynchronously, the block SHALL set: row=8'hFF, colg=8'h00, colr=8'h00, frame_done=0.
REQ-027 While dst==1, the block SHALL set div=0, ridx=0 and frame counter=0.
REQ-028 While dst==1, the block SHALL set num_l=15, fail_l=0, blink_l=0 and ph=1.
REQ-029 On the first clk after dst falls, the block SHALL drive row=8'hFE with blank columns; the first frame after reset is always blank.
REQ-030 Asserting dst mid-frame SHALL abort the scan immediately; no partial row or pulse SHALL complete.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset check: dst=1 -> row=FF, colg=colr=00, frame_done=0. Release dst -> next cycle row=FE, columns 00 for 32 cycles.
REQ-032 Red scan: num=14, fail=0, blink=0 held -> after the first boundary, colr=FF and colg=00. Row SHALL step FE,FD,FB,F7,EF,DF,BF,7F, holding each value 4 cycles, and frame_done SHALL pulse every 32 cycles.
REQ-033 Colour change without tearing: drive fail=1 while ridx=3 -> colr stays FF through 7F. Coincident with the next frame_done, colg=FF and colr=00.
REQ-034 Blink: num=14, blink=1 -> columns alternate 2 frames FF, then 2 frames 00 (starting from the ph value at latch). Row continues scanning throughout.
REQ-035 Mid-frame reset: dst pulsed at ridx=5 -> in the same cycle row=FF and columns 00. After release the scan restarts at FE and the display is blank for one frame.
REQ-036 Pattern switch: num 14->15 mid-row -> columns stay FF until the boundary, then 00 for all rows.

Source files
------------

// File: rtl/dz_scan.sv
// Bicolour 8x8 LED matrix scanner: one row per SCAN_DIV cycles, image/colour/blink latched per frame.
// Outputs are registered (1-cycle latency); no backpressure, the scan free-runs.
module dz_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       dst,
  input  logic [3:0] num,
  input  logic       fail,
  input  logic       blink,
  output logic [7:0] row,
  output logic [7:0] colg,
  output logic [7:0] colr,
  output logic       frame_done
);

  logic [15:0] div_q, div_d;
  logic [2:0]  ridx_q, ridx_d;
  logic [7:0]  frm_q, frm_d;
  logic        ph_q, ph_d;
  logic [3:0]  num_q, num_d;
  logic        fail_q, fail_d;
  logic        blink_q, blink_d;
  logic [7:0]  row_q, row_d, colg_q, colg_d, colr_q, colr_d;
  logic        fd_q, fd_d;
  logic        tc, bnd;
  logic [7:0]  pat;

  // Row 0 is the top byte of each image; bit 7 is the leftmost column.
  function automatic logic [7:0] rom_row(input logic [3:0] n, input logic [2:0] r);
    logic [63:0] img;
    case (n)
      4'd0:    img = 64'h3C42A581A599423C;
      4'd1:    img = 64'h3C42A58199A5423C;
      4'd2:    img = 64'h66FFFFFF7E3C1800;
      4'd3:    img = 64'h8142241818244281;
      4'd4:    img = 64'h0001020488502000;
      4'd5:    img = 64'h183C7E1818181818;
      4'd6:    img = 64'h18181818187E3C18;
      4'd7:    img = 64'h3C7EDBFFFF7E5A00;
      4'd8:    img = 64'h3C7EDBFFFFFFFFA5;
      4'd9:    img = 64'h183C7EDBFF245AA5;
      4'd10:   img = 64'h183C7EFFFF7E3C18;
      4'd11:   img = 64'h181818FFFF181818;
      4'd12:   img = 64'hFF818181818181FF;
      4'd13:   img = 64'hAA55AA55AA55AA55;
      4'd14:   img = 64'hFFFFFFFFFFFFFFFF;
      default: img = 64'h0000000000000000;
    endcase
    return img[{~r, 3'b000} +: 8];
  endfunction

  assign tc  = (div_q == 16'(SCAN_DIV - 1));
  assign bnd = tc && (ridx_q == 3'd7);

  always_comb begin
    div_d   = tc ? 16'd0 : div_q + 16'd1;
    ridx_d  = tc ? ridx_q + 3'd1 : ridx_q;
    frm_d   = frm_q;
    ph_d    = ph_q;
    num_d   = num_q;
    fail_d  = fail_q;
    blink_d = blink_q;
    // Shadow inputs only at the frame boundary so a frame never tears.
    if (bnd) begin
      num_d   = num;
      fail_d  = fail;
      blink_d = blink;
      if (frm_q == 8'(BLINK_FRAMES - 1)) begin
        frm_d = 8'd0;
        ph_d  = ~ph_q;
      end else begin
        frm_d = frm_q + 8'd1;
      end
    end

    pat = rom_row(num_q, ridx_q);
    if (blink_q && !ph_q) pat = 8'h00;
    row_d  = ~(8'd1 << ridx_q);
    colg_d = fail_q ? pat : 8'h00;
    colr_d = fail_q ? 8'h00 : pat;
    fd_d   = (div_q == 16'd0) && (ridx_q == 3'd0);
  end

  always_ff @(posedge clk or posedge dst) begin
    if (dst) begin
      div_q   <= 16'd0;
      ridx_q  <= 3'd0;
      frm_q   <= 8'd0;
      ph_q    <= 1'b1;
      num_q   <= 4'd15;
      fail_q  <= 1'b0;
      blink_q <= 1'b0;
      row_q   <= 8'hFF;
      colg_q  <= 8'h00;
      colr_q  <= 8'h00;
      fd_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      ridx_q  <= ridx_d;
      frm_q   <= frm_d;
      ph_q    <= ph_d;
      num_q   <= num_d;
      fail_q  <= fail_d;
      blink_q <= blink_d;
      row_q   <= row_d;
      colg_q  <= colg_d;
      colr_q  <= colr_d;
      fd_q    <= fd_d;
    end
  end

  assign row        = row_q;
  assign colg       = colg_q;
  assign colr       = colr_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_dz_scan.sv
// Bench for dz_scan with SCAN_DIV=4, BLINK_FRAMES=2: frame-level model plus directed pins.
module tb_dz_scan;
  logic       clk, dst, fail, blink, frame_done;
  logic [3:0] num;
  logic [7:0] row, colg, colr;

  int n_checks = 0;
  int n_pass   = 0;
  logic run;

  dz_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .dst(dst), .num(num), .fail(fail), .blink(blink),
    .row(row), .colg(colg), .colr(colr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
  endtask

  // Model: c counts clock edges since reset release. Row = (c/4)%8, frame = c/32;
  // after f frame boundaries the blink phase has toggled floor(f/2) times from 1.
  int         c;
  logic [3:0] m_num;
  logic       m_fail, m_blink;
  logic [7:0] e_row, e_colg, e_colr;
  logic       e_fd;

  function automatic logic [15:0] exp_cols(input int cc, input logic [3:0] n,
                                           input logic f, input logic b);
    int         fr;
    logic       ph;
    logic [7:0] d;
    fr = cc / 32;
    ph = ((fr / 2) % 2) == 0;
    d  = (n == 4'd14) ? 8'hFF : 8'h00;
    if (b && !ph) d = 8'h00;
    return f ? {d, 8'h00} : {8'h00, d};
  endfunction

  always @(posedge clk or posedge dst) begin
    if (dst) begin
      c       <= 0;
      m_num   <= 4'd15;
      m_fail  <= 1'b0;
      m_blink <= 1'b0;
      e_row   <= 8'hFF;
      e_colg  <= 8'h00;
      e_colr  <= 8'h00;
      e_fd    <= 1'b0;
    end else begin
      e_row  <= 8'(~(8'd1 << ((c / 4) % 8)));
      {e_colg, e_colr} <= exp_cols(c, m_num, m_fail, m_blink);
      e_fd   <= (c % 32) == 0;
      if ((c % 32) == 31) begin
        m_num   <= num;
        m_fail  <= fail;
        m_blink <= blink;
      end
      c <= c + 1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("row", row, e_row);
      check("colg", colg, e_colg);
      check("colr", colr, e_colr);
      check("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0; dst = 1'b1; num = 4'd14; fail = 1'b0; blink = 1'b0; run = 1'b0;
    tick(2);
    run = 1'b1;
    tick(1);
    check("rst_row", row, 8'hFF);
    check("rst_colg", colg, 8'h00);
    check("rst_colr", colr, 8'h00);
    check("rst_fd", {7'd0, frame_done}, 8'h00);
    #1 dst = 1'b0;

    tick(1);   // first edge after release
    check("e1_row", row, 8'hFE);
    check("e1_fd", {7'd0, frame_done}, 8'h01);
    check("e1_colr_blank", colr, 8'h00);
    tick(32);  // first row of frame 1
    check("f1_colr", colr, 8'hFF);
    check("f1_colg", colg, 8'h00);
    check("f1_fd", {7'd0, frame_done}, 8'h01);
    tick(4);
    check("f1_row1", row, 8'hFD);
    tick(8);   // ridx 3
    check("f1_row3", row, 8'hF7);
    #1 fail = 1'b1;
    tick(16);
    check("f1_row7", row, 8'h7F);
    check("f1_row7_colr", colr, 8'hFF);
    tick(3);
    check("f1_last_colr", colr, 8'hFF);
    tick(1);   // frame 2 start, green now
    check("f2_colg", colg, 8'hFF);
    check("f2_colr", colr, 8'h00);
    check("f2_fd", {7'd0, frame_done}, 8'h01);
    #1 blink = 1'b1;
    tick(32);  // frame 3: phase 0, blanked
    check("f3_blank", colg, 8'h00);
    check("f3_row", row, 8'hFE);
    tick(32);  // frame 4: phase 1
    check("f4_lit", colg, 8'hFF);
    tick(64);  // frame 6: phase 0
    check("f6_blank", colg, 8'h00);
    #1 blink = 1'b0;
    tick(52);  // frame 7, ridx 5
    check("f7_row5", row, 8'hDF);
    #1 dst = 1'b1;
    #1;
    check("mid_rst_row", row, 8'hFF);
    check("mid_rst_colg", colg, 8'h00);
    check("mid_rst_fd", {7'd0, frame_done}, 8'h00);
    tick(2);
    #1 dst = 1'b0;

    tick(1);
    check("r2_row", row, 8'hFE);
    check("r2_colg_blank", colg, 8'h00);
    tick(32);
    check("r2_f1_colg", colg, 8'hFF);
    check("r2_f1_colr", colr, 8'h00);
    tick(9);
    #1 num = 4'd15;
    tick(22);
    check("sw_hold", colg, 8'hFF);
    tick(1);
    check("sw_blank", colg, 8'h00);
    tick(7);
    check("sw_blank_r2", colg, 8'h00);
    tick(40);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
